// File: rtl/led_frame_bank_sched.sv
// Triple-buffer bank scheduler between the LED capture writer and the PWM scan-out reader.
// Tracks per-bank ownership and drives bank selects, base addresses and drop/repeat statistics.
module led_frame_bank_sched #(
  parameter int unsigned FRAME_WORDS = 512,
  parameter int unsigned AW          = 11,
  parameter int unsigned CW          = 8
) (
  input  logic          GCK,
  input  logic          rst_n,
  input  logic          wr_start,
  input  logic          wr_done,
  input  logic          rd_frame,
  input  logic          mode,
  output logic [1:0]    wr_bank,
  output logic [AW-1:0] wr_base,
  output logic          wr_busy,
  output logic [1:0]    rd_bank,
  output logic [AW-1:0] rd_base,
  output logic          rd_valid,
  output logic          new_frame,
  output logic          err_overrun,
  output logic [CW-1:0] drop_cnt,
  output logic [CW-1:0] repeat_cnt
);

  localparam int unsigned   NB      = 3;
  localparam logic [AW-1:0] FW_A    = AW'(FRAME_WORDS);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    B_FREE,
    B_WRITING,
    B_READY,
    B_READING
  } bank_st_e;

  bank_st_e      st_q [NB];
  bank_st_e      st_d [NB];
  logic [1:0]    wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_base_q, wr_base_d;
  logic          wr_busy_q, wr_busy_d;
  logic [1:0]    rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_base_q, rd_base_d;
  logic          rd_valid_q, rd_valid_d;
  logic          new_frame_q, new_frame_d;
  logic          err_overrun_q, err_overrun_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] repeat_cnt_q, repeat_cnt_d;
  logic          phase_q, phase_d;

  logic          swap_opp_c;
  logic [NB-1:0] free_pre_c;
  logic          rdy_found_c;
  logic [1:0]    rdy_idx_c;
  logic [1:0]    alloc_idx_c;

  // Ordered per-cycle update: completion, then reader swap, then allocation from the pre-swap free set.
  always_comb begin
    for (int unsigned i = 0; i < NB; i++) st_d[i] = st_q[i];
    wr_bank_d     = wr_bank_q;
    wr_busy_d     = wr_busy_q;
    rd_bank_d     = rd_bank_q;
    rd_valid_d    = rd_valid_q;
    new_frame_d   = 1'b0;
    err_overrun_d = 1'b0;
    drop_cnt_d    = drop_cnt_q;
    repeat_cnt_d  = repeat_cnt_q;
    free_pre_c    = '0;
    rdy_found_c   = 1'b0;
    rdy_idx_c     = 2'd0;
    alloc_idx_c   = 2'd0;

    swap_opp_c = rd_frame & (~mode | phase_q);
    if (!mode) begin
      phase_d = 1'b0;
    end else if (rd_frame) begin
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end

    if (wr_done && wr_busy_q) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (st_d[i] == B_READY) begin
          st_d[i] = B_FREE;
          if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CW'(1);
        end
      end
      st_d[wr_bank_q] = B_READY;
      wr_busy_d       = 1'b0;
    end

    for (int unsigned i = 0; i < NB; i++) free_pre_c[i] = (st_d[i] == B_FREE);

    if (swap_opp_c) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (st_d[i] == B_READY) begin
          rdy_found_c = 1'b1;
          rdy_idx_c   = 2'(i);
        end
      end
      if (rdy_found_c) begin
        st_d[rd_bank_q] = B_FREE;
        st_d[rdy_idx_c] = B_READING;
        rd_bank_d       = rdy_idx_c;
        rd_valid_d      = 1'b1;
        new_frame_d     = 1'b1;
      end else if (rd_valid_q && (repeat_cnt_q != CNT_MAX)) begin
        repeat_cnt_d = repeat_cnt_q + CW'(1);
      end
    end

    if (wr_start) begin
      if (wr_busy_d) begin
        err_overrun_d = 1'b1;
      end else begin
        for (int i = int'(NB) - 1; i >= 0; i--) begin
          if (free_pre_c[i]) alloc_idx_c = 2'(i);
        end
        st_d[alloc_idx_c] = B_WRITING;
        wr_bank_d         = alloc_idx_c;
        wr_busy_d         = 1'b1;
      end
    end

    wr_base_d = AW'(wr_bank_d) * FW_A;
    rd_base_d = AW'(rd_bank_d) * FW_A;
  end

  always_ff @(posedge GCK or negedge rst_n) begin
    if (!rst_n) begin
      st_q[0]       <= B_FREE;
      st_q[1]       <= B_FREE;
      st_q[2]       <= B_READING;
      wr_bank_q     <= 2'd0;
      wr_base_q     <= '0;
      wr_busy_q     <= 1'b0;
      rd_bank_q     <= 2'd2;
      rd_base_q     <= AW'(2) * FW_A;
      rd_valid_q    <= 1'b0;
      new_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      drop_cnt_q    <= '0;
      repeat_cnt_q  <= '0;
      phase_q       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) st_q[i] <= st_d[i];
      wr_bank_q     <= wr_bank_d;
      wr_base_q     <= wr_base_d;
      wr_busy_q     <= wr_busy_d;
      rd_bank_q     <= rd_bank_d;
      rd_base_q     <= rd_base_d;
      rd_valid_q    <= rd_valid_d;
      new_frame_q   <= new_frame_d;
      err_overrun_q <= err_overrun_d;
      drop_cnt_q    <= drop_cnt_d;
      repeat_cnt_q  <= repeat_cnt_d;
      phase_q       <= phase_d;
    end
  end

  assign wr_bank     = wr_bank_q;
  assign wr_base     = wr_base_q;
  assign wr_busy     = wr_busy_q;
  assign rd_bank     = rd_bank_q;
  assign rd_base     = rd_base_q;
  assign rd_valid    = rd_valid_q;
  assign new_frame   = new_frame_q;
  assign err_overrun = err_overrun_q;
  assign drop_cnt    = drop_cnt_q;
  assign repeat_cnt  = repeat_cnt_q;

endmodule

// File: tb/tb_led_frame_bank_sched.sv
// Directed bench for led_frame_bank_sched: hand-derived expected outputs queued per step, compared after each edge.
module tb_led_frame_bank_sched;

  localparam int unsigned FW = 512;
  localparam int unsigned AW = 11;
  localparam int unsigned CW = 8;

  logic          GCK = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_start = 1'b0;
  logic          wr_done = 1'b0;
  logic          rd_frame = 1'b0;
  logic          mode = 1'b0;
  logic [1:0]    wr_bank;
  logic [AW-1:0] wr_base;
  logic          wr_busy;
  logic [1:0]    rd_bank;
  logic [AW-1:0] rd_base;
  logic          rd_valid;
  logic          new_frame;
  logic          err_overrun;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] repeat_cnt;

  led_frame_bank_sched #(.FRAME_WORDS(FW), .AW(AW), .CW(CW)) dut (
    .GCK(GCK), .rst_n(rst_n), .wr_start(wr_start), .wr_done(wr_done),
    .rd_frame(rd_frame), .mode(mode), .wr_bank(wr_bank), .wr_base(wr_base),
    .wr_busy(wr_busy), .rd_bank(rd_bank), .rd_base(rd_base), .rd_valid(rd_valid),
    .new_frame(new_frame), .err_overrun(err_overrun), .drop_cnt(drop_cnt),
    .repeat_cnt(repeat_cnt)
  );

  always #5 GCK = ~GCK;

  typedef struct {
    string         tag;
    logic [1:0]    wb;
    logic          busy;
    logic [1:0]    rb;
    logic          rv;
    logic          nf;
    logic          ov;
    logic [CW-1:0] dc;
    logic [CW-1:0] rc;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input string fld, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = q.pop_front();
    chk(e.tag, "wr_bank",     16'(wr_bank),     16'(e.wb));
    chk(e.tag, "wr_base",     16'(wr_base),     16'(e.wb) * 16'(FW));
    chk(e.tag, "wr_busy",     16'(wr_busy),     16'(e.busy));
    chk(e.tag, "rd_bank",     16'(rd_bank),     16'(e.rb));
    chk(e.tag, "rd_base",     16'(rd_base),     16'(e.rb) * 16'(FW));
    chk(e.tag, "rd_valid",    16'(rd_valid),    16'(e.rv));
    chk(e.tag, "new_frame",   16'(new_frame),   16'(e.nf));
    chk(e.tag, "err_overrun", 16'(err_overrun), 16'(e.ov));
    chk(e.tag, "drop_cnt",    16'(drop_cnt),    16'(e.dc));
    chk(e.tag, "repeat_cnt",  16'(repeat_cnt),  16'(e.rc));
  endtask

  task automatic reset_exp(input string tag);
    cur.tag  = tag;
    cur.wb   = 2'd0;
    cur.busy = 1'b0;
    cur.rb   = 2'd2;
    cur.rv   = 1'b0;
    cur.nf   = 1'b0;
    cur.ov   = 1'b0;
    cur.dc   = '0;
    cur.rc   = '0;
  endtask

  task automatic step(input string tag, input logic ws, input logic wd, input logic rf);
    cur.tag = tag;
    q.push_back(cur);
    cur.nf = 1'b0;
    cur.ov = 1'b0;
    wr_start = ws;
    wr_done  = wd;
    rd_frame = rf;
    @(posedge GCK);
    #1;
    wr_start = 1'b0;
    wr_done  = 1'b0;
    rd_frame = 1'b0;
    check_front();
  endtask

  task automatic idle_rf(input int n);
    for (int k = 0; k < n; k++) begin
      rd_frame = 1'b1;
      @(posedge GCK);
      #1;
      rd_frame = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge GCK);
    #1;
    reset_exp("reset");
    q.push_back(cur);
    check_front();
    rst_n = 1'b1;

    // First frame written and displayed
    cur.wb = 2'd0; cur.busy = 1'b1;                 step("t1_start", 1, 0, 0);
    cur.busy = 1'b0;                                step("t1_done", 0, 1, 0);
    cur.rb = 2'd0; cur.rv = 1'b1; cur.nf = 1'b1;    step("t1_swap", 0, 0, 1);
    step("t1_idle", 0, 0, 0);
    cur.wb = 2'd1; cur.busy = 1'b1;                 step("t1_start2", 1, 0, 0);
    cur.busy = 1'b0;                                step("t1_done2", 0, 1, 0);
    cur.wb = 2'd2; cur.busy = 1'b1;                 step("t1_start3", 1, 0, 0);
    cur.ov = 1'b1;                                  step("overrun", 1, 0, 0);
    step("overrun_idle", 0, 0, 0);

    // Asynchronous reset in the middle of a write
    #2;
    rst_n = 1'b0;
    #1;
    reset_exp("async_rst");
    q.push_back(cur);
    check_front();
    @(posedge GCK);
    #1;
    rst_n = 1'b1;

    // Three frames with no reader: writes go 0,1,0 and two frames are dropped
    cur.wb = 2'd0; cur.busy = 1'b1;                 step("t2_start_a", 1, 0, 0);
    cur.busy = 1'b0;                                step("t2_done_a", 0, 1, 0);
    cur.wb = 2'd1; cur.busy = 1'b1;                 step("t2_start_b", 1, 0, 0);
    cur.busy = 1'b0; cur.dc = 8'd1;                 step("t2_done_b", 0, 1, 0);
    cur.wb = 2'd0; cur.busy = 1'b1;                 step("t2_start_c", 1, 0, 0);
    cur.busy = 1'b0; cur.dc = 8'd2;                 step("t2_done_c", 0, 1, 0);

    // Completion and swap in the same cycle
    cur.rb = 2'd0; cur.rv = 1'b1; cur.nf = 1'b1;    step("t5_swap0", 0, 0, 1);
    cur.wb = 2'd1; cur.busy = 1'b1;                 step("t5_start", 1, 0, 0);
    cur.busy = 1'b0; cur.rb = 2'd1; cur.nf = 1'b1;  step("t5_done_swap", 0, 1, 1);
    step("t5_idle", 0, 0, 0);

    // Start and done together: completion first, then allocate
    cur.wb = 2'd0; cur.busy = 1'b1;                 step("sd_start", 1, 0, 0);
    cur.wb = 2'd2; cur.busy = 1'b1;                 step("sd_start_done", 1, 1, 0);
    cur.busy = 1'b0; cur.dc = 8'd3;                 step("sd_done", 0, 1, 0);

    // 60fps mode: only every second rd_frame is a swap opportunity
    mode = 1'b1;
    step("m1_rf1", 0, 0, 1);
    cur.rb = 2'd2; cur.nf = 1'b1;                   step("m1_rf2", 0, 0, 1);
    step("m1_rf3", 0, 0, 1);
    cur.rc = 8'd1;                                  step("m1_rf4", 0, 0, 1);

    // Start during swap uses the pre-swap free set
    mode = 1'b0;
    cur.wb = 2'd0; cur.busy = 1'b1;                 step("ss_start", 1, 0, 0);
    cur.busy = 1'b0;                                step("ss_done", 0, 1, 0);
    cur.wb = 2'd1; cur.busy = 1'b1; cur.rb = 2'd0; cur.nf = 1'b1; step("ss_start_swap_a", 1, 0, 1);
    cur.busy = 1'b0;                                step("ss_done_b", 0, 1, 0);
    cur.wb = 2'd2; cur.busy = 1'b1; cur.rb = 2'd1; cur.nf = 1'b1; step("ss_start_swap_b", 1, 0, 1);
    cur.busy = 1'b0;                                step("ss_done_c", 0, 1, 0);
    cur.rb = 2'd2; cur.nf = 1'b1;                   step("ss_swap_c", 0, 0, 1);

    // Repeat counter saturation with nothing ready
    idle_rf(252);
    cur.rc = 8'd254;                                step("rep_254", 0, 0, 1);
    idle_rf(45);
    cur.rc = 8'd255;                                step("rep_sat", 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_frame_bank_sched.md
Name: led_frame_bank_sched

Overview:
- Triple-buffer scheduler for the LED driver frame store: three frame banks of FRAME_WORDS 16-bit words shared between the pixel-capture writer and the PWM scan-out reader.
- Allocates a free bank to each incoming frame and hands the newest completed frame to the reader at display-frame boundaries.
- Ensures the reader never reads a bank being written, and counts dropped and repeated frames.
- Sits between the capture FSM (write side) and the scan-out FSM (read side); drives only bank selects and base addresses, not the SRAM itself.

Parameters:
- FRAME_WORDS, 512, words per frame bank.
- AW, 11, physical address width; must hold 3*FRAME_WORDS.
- CW, 8, width of the drop/repeat statistics counters.

Ports:
- GCK  input  1  single clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- wr_start  input  1  pulse: writer begins a new frame.
- wr_done  input  1  pulse: writer finished the current frame.
- rd_frame  input  1  pulse: reader is at a display-frame boundary and requests a bank for the next frame.
- mode  input  1  0 = 30fps (swap on every rd_frame), 1 = 60fps (swap only on every second rd_frame).
- wr_bank  output  2  bank the writer must use (0..2).
- wr_base  output  AW  wr_bank*FRAME_WORDS.
- wr_busy  output  1  a write bank is allocated.
- rd_bank  output  2  bank the reader must use.
- rd_base  output  AW  rd_bank*FRAME_WORDS.
- rd_valid  output  1  rd_bank holds a completed frame.
- new_frame  output  1  one-cycle pulse: rd_bank switched to a newer frame.
- err_overrun  output  1  one-cycle pulse: wr_start arrived while wr_busy.
- drop_cnt  output  CW  completed frames discarded without being displayed; saturating.
- repeat_cnt  output  CW  swap opportunities with no newer frame available; saturating.

Behaviour:
- Each bank is in one of four states: FREE, WRITING, READY, READING. At most one bank is WRITING, one READY and one READING.
- Reset (async, rst_n=0):
  - Bank 0 and bank 1 FREE, bank 2 READING.
  - wr_bank=0, rd_bank=2, wr_busy=0, rd_valid=0.
  - new_frame=0, err_overrun=0, drop_cnt=0, repeat_cnt=0.
  - Internal 60fps phase bit=0.
- All outputs are registered; every decision below is visible on the cycle after the input pulse.
- wr_start, wr_busy=0:
  - Pick the lowest-index FREE bank, set it WRITING, set wr_bank to it, wr_busy=1.
  - A FREE bank always exists here by construction.
- wr_start, wr_busy=1:
  - The current WRITING bank restarts in place (same wr_bank).
  - err_overrun pulses.
  - No other state changes.
- wr_done, wr_busy=1:
  - WRITING bank becomes READY; wr_busy=0.
  - If another bank was already READY, it becomes FREE and drop_cnt increments.
- wr_done, wr_busy=0: ignored.
- rd_frame phase:
  - mode=1: the phase bit toggles on each rd_frame, and only a rd_frame arriving with phase=1 is a swap opportunity.
  - mode=0: every rd_frame is a swap opportunity and the phase bit is held at 0.
- Swap opportunity with a READY bank:
  - READING bank becomes FREE; READY bank becomes READING.
  - rd_bank updates; rd_valid=1; new_frame pulses.
- Swap opportunity with no READY bank:
  - rd_bank unchanged.
  - repeat_cnt increments, but only if rd_valid=1.
- Simultaneous wr_done and swap opportunity in the same cycle:
  - wr_done is applied first, so the frame just completed is handed to the reader in that cycle.
  - new_frame pulses; no drop for that frame.
- Simultaneous wr_start and wr_done (wr_busy=1):
  - Complete the current bank first, then allocate a new bank for wr_start.
  - The allocation sees the post-completion FREE set; err_overrun stays 0.
- Simultaneous wr_start and swap:
  - The bank freed by the swap is not eligible for allocation in that same cycle.
  - Allocation uses the pre-swap FREE set.
- mode change takes effect at the next rd_frame; the phase bit resets to 0 when mode is 0.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-frame returns everything to reset state immediately; any partially written frame is discarded without counting.

Test Plan:
- Reset, wr_start, wr_done, rd_frame (mode=0) -> wr_bank=0; then rd_bank=0, rd_valid=1, new_frame one pulse, bank 2 FREE.
- Three frames completed with no rd_frame -> banks cycle 0→1→0 for writes (lowest FREE bank each time), drop_cnt=2, one READY bank remains.
- mode=1, one frame READY, two rd_frame pulses -> swap only on the second pulse; the first leaves rd_bank unchanged without counting a repeat.
- mode=0, rd_valid=1, rd_frame with nothing READY, repeated 300 times -> rd_bank unchanged, repeat_cnt saturates at 255.
- wr_done and rd_frame in the same cycle -> new_frame pulses, reader takes the just-completed bank, drop_cnt unchanged.
- wr_start while wr_busy -> err_overrun one pulse, wr_bank unchanged; rst_n low mid-write -> all outputs at reset values asynchronously.
